// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI request arbiter.
//   arb_state_t    : arbiter FSM states
//   SPI_ADDR_LIMIT : first address the controller rejects (ERROR path, cs_n high)
//   DEF_PARK_ADDR  : default idle ("park") address, out of range on purpose
//   id_width()     : width of a requester index for n requesters
package spi_arb_pkg;

  typedef enum logic [1:0] {
    PARK    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam int         SPI_ADDR_LIMIT = 32;
  localparam logic [7:0] DEF_PARK_ADDR  = 8'hFF;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index (search starts here and wraps)
//   valid_o : any request present
//   idx_o   : index of the winner
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [id_width(NUM_REQ)-1:0]    ptr_i,
  output logic                            valid_o,
  output logic [id_width(NUM_REQ)-1:0]    idx_o
);

  localparam int IW = id_width(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW:0]          off;
  logic [IW:0]          sum;

  // Rotate so the pointer lands on bit 0, find the lowest set bit, then
  // add the pointer back modulo NUM_REQ.
  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[NUM_REQ-1:0];
    valid_o = |rot;
    off     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one spi_controller between NUM_REQ requesters.
//   Requester side : req/req_wr/req_addr/req_wdata in; ack (one-hot pulse),
//                    resp_rdata/resp_error/resp_timeout out (held until next ack).
//   Status         : busy, grant_id (current or last grantee).
//   Controller side: spi_write_en/spi_addr/spi_wdata/spi_rst_n out;
//                    spi_done/spi_error/spi_rdata in.
// The command only changes on a spi_done edge, so every spi_done belongs to
// the command loaded at the previous spi_done. With no work the controller
// is parked on an out-of-range address, which loops through its ERROR path
// without touching the bus and keeps spi_done ticking for the arbiter.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter int         TIMEOUT   = 1024,
  parameter int         RST_HOLD  = 2,
  parameter logic [7:0] PARK_ADDR = DEF_PARK_ADDR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [8*NUM_REQ-1:0]         req_addr,
  input  logic [8*NUM_REQ-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [7:0]                   resp_rdata,
  output logic                         resp_error,
  output logic                         resp_timeout,
  output logic                         busy,
  output logic [id_width(NUM_REQ)-1:0] grant_id,
  output logic                         spi_write_en,
  output logic [7:0]                   spi_addr,
  output logic [7:0]                   spi_wdata,
  output logic                         spi_rst_n,
  input  logic                         spi_done,
  input  logic                         spi_error,
  input  logic [7:0]                   spi_rdata
);

  localparam int IW = id_width(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  arb_state_t               state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [7:0]               rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     to_q, to_d;
  logic                     wr_q, wr_d;
  logic [7:0]               addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     srst_q, srst_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [HW-1:0]            hold_q, hold_d;

  logic [NUM_REQ-1:0][7:0]  addr_a, wdata_a;
  logic [NUM_REQ-1:0]       pick_req;
  logic [IW-1:0]            pick_ptr;
  logic                     pick_vld;
  logic [IW-1:0]            pick_idx;
  logic                     do_grant, do_park;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    logic [IW:0] s;
    s = {1'b0, v} + (IW+1)'(1);
    if (s >= (IW+1)'(NUM_REQ)) s = '0;
    return s[IW-1:0];
  endfunction

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  // On a completion edge the finishing requester still has req high; mask it
  // so a back-to-back grant only goes to someone else.
  assign pick_req = (state_q == BUSY) ? (req & ~(NUM_REQ'(1) << grant_q)) : req;
  assign pick_ptr = (state_q == BUSY) ? wrap_inc(grant_q) : ptr_q;

  spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    srst_d   = srst_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    do_park  = 1'b0;

    case (state_q)
      PARK: begin
        srst_d = 1'b1;  // also releases the controller after a global reset
        if (spi_done && pick_vld) do_grant = 1'b1;
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // spi_done has priority over a simultaneous timeout.
        if (spi_done) begin
          ack_d[grant_q] = 1'b1;
          rdata_d        = spi_rdata;
          err_d          = spi_error;
          to_d           = 1'b0;
          ptr_d          = wrap_inc(grant_q);
          if (pick_vld) begin
            do_grant = 1'b1;
          end else begin
            do_park = 1'b1;
            busy_d  = 1'b0;
            state_d = PARK;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ack_d[grant_q] = 1'b1;
          rdata_d        = '0;
          err_d          = 1'b1;
          to_d           = 1'b1;
          ptr_d          = wrap_inc(grant_q);
          srst_d         = 1'b0;
          hold_d         = '0;
          do_park        = 1'b1;
          state_d        = RECOVER;
        end
      end
      RECOVER: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(RST_HOLD - 1)) begin
          srst_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = PARK;
        end
      end
      default: state_d = PARK;
    endcase

    if (do_grant) begin
      grant_d = pick_idx;
      wr_d    = req_wr[pick_idx];
      addr_d  = addr_a[pick_idx];
      wdata_d = wdata_a[pick_idx];
      busy_d  = 1'b1;
      cnt_d   = '0;
      state_d = BUSY;
    end
    if (do_park) begin
      wr_d    = 1'b0;
      addr_d  = PARK_ADDR;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PARK;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= PARK_ADDR;
      wdata_q <= '0;
      srst_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      srst_q  <= srst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign ack          = ack_q;
  assign resp_rdata   = rdata_q;
  assign resp_error   = err_q;
  assign resp_timeout = to_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign spi_write_en = wr_q;
  assign spi_addr     = addr_q;
  assign spi_wdata    = wdata_q;
  assign spi_rst_n    = srst_q;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one `spi_controller` between NUM_REQ independent requesters, using round-robin arbitration.
- Drives the controller's `write_en`/`addr`/`data_in` and returns `data_out`/`error` to the winning requester.
- Parks the controller on a harmless out-of-range command when there is no work.
- Watchdogs each transaction and resets the controller if it hangs, for example when `op_done` never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, cycles allowed from command load to `spi_done` before recovery
RST_HOLD, 2, cycles `spi_rst_n` is held low during recovery
PARK_ADDR, 8'hFF, address driven while idle; must be >= 32 so the controller takes its ERROR path with `cs_n` high

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low; synchronous deassert handled upstream
req  in  NUM_REQ  per-requester request level; held until the matching ack pulse
req_wr  in  NUM_REQ  per-requester write(1)/read(0)
req_addr  in  8*NUM_REQ  packed addresses, requester i at [8i+7:8i]
req_wdata  in  8*NUM_REQ  packed write data
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
resp_rdata  out  8  read data, valid with ack
resp_error  out  1  controller error (address >= 32) or timeout, valid with ack
resp_timeout  out  1  transaction aborted by watchdog, valid with ack
busy  out  1  a granted command is in flight
grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee
spi_write_en  out  1  to controller `write_en`
spi_addr  out  8  to controller `addr`
spi_wdata  out  8  to controller `data_in`
spi_rst_n  out  1  to controller `rst_n` (synchronous in the controller)
spi_done  in  1  controller `done`
spi_error  in  1  controller `error`
spi_rdata  in  8  controller `data_out`

Behaviour:
- Reset values:
  - state PARK; `ack` 0; `resp_*` 0; `busy` 0; `grant_id` 0; RR pointer 0.
  - `spi_addr` PARK_ADDR; `spi_write_en` 0; `spi_wdata` 0.
  - `spi_rst_n` 0, released to 1 on the first clock edge after `rst_n` deasserts.
  - Timeout counter 0.
- Command-change rule: `spi_*` command outputs change only on a clock edge where `spi_done`=1. The controller then sits in IDLE and samples the new command in LOAD on the next cycle. Each `spi_done` therefore belongs to the command loaded at the previous `spi_done` edge.
- PARK:
  - Outputs the park command; the controller loops IDLE->LOAD->CHECK_OP->ERROR with no bus activity.
  - On `spi_done`=1 with any `req` bit set:
    - Pick the winner, round-robin from the pointer (pointer = last winner + 1, mod NUM_REQ).
    - Register its wr/addr/wdata onto `spi_*` and set `grant_id`.
    - Set `busy`=1, clear the counter, go to BUSY.
  - `spi_done` with no request: stay in PARK.
- BUSY:
  - Command held constant; counter increments each cycle.
  - On `spi_done`=1 at that edge:
    - `ack[grant_id]`=1, `resp_rdata`=`spi_rdata`, `resp_error`=`spi_error`, `resp_timeout`=0.
    - Pointer = `grant_id`+1.
    - If another `req` bit is set, excluding the just-acked requester's bit at this edge, grant the next winner in the same edge (back-to-back, stay in BUSY).
    - Otherwise load the park command, `busy`=0, go to PARK.
  - On counter = TIMEOUT-1 without `spi_done`:
    - `ack[grant_id]`=1, `resp_error`=1, `resp_timeout`=1, `resp_rdata`=0.
    - `spi_rst_n`=0, load the park command, go to RECOVER.
  - `spi_done` and timeout on the same cycle: `spi_done` wins and the response is normal.
- RECOVER:
  - Holds `spi_rst_n`=0 for RST_HOLD cycles, then sets it to 1 and goes to PARK.
  - `busy` stays 1 until PARK is entered.
  - In PARK, the next `spi_done` (after the controller's park loop, about 4 cycles) re-enables granting.
- Outputs:
  - `ack`, `resp_*` and `grant_id` are registered.
  - `ack` lasts exactly one cycle.
  - `resp_*` hold their value until the next ack.
- Requester-side rules:
  - A requester that deasserts `req` before its ack is still acked; the latched fields are used.
  - A requester that keeps `req` high after its ack is re-arbitrated as a new request.
- Async `rst_n` mid-transaction: everything returns to reset values immediately, and `spi_rst_n` drops with it.

Decomposition:
- Package `spi_arb_pkg`:
  - state enum `arb_state_t` {PARK, BUSY, RECOVER};
  - constants `SPI_ADDR_LIMIT`=32 and default PARK_ADDR;
  - a function returning the ID width.
- Sub-module `spi_rr_pick`: combinational round-robin picker (`req`, pointer -> valid, index).

Test Plan:
- Single write, req0: wr=1, addr=8'h05, wdata=8'hA5, controller `op_done` tied 1 -> `spi_addr`=5 after the first park done; `ack[0]` pulses; `resp_error`=0.
- Read with `miso` pattern 8'h3C on req2, addr=8'h10 -> `ack[2]`, `resp_rdata`=8'h3C, `resp_error`=0.
- All four requesters asserted together from reset -> acks in order 0,1,2,3 with no park cycles between them; `grant_id` sequence 0,1,2,3.
- req1 addr=8'h40 -> `ack[1]` with `resp_error`=1, `resp_timeout`=0; no `cs_n` low cycle on the bus.
- Write with `op_done` held 0, TIMEOUT=16 -> `ack` at cycle 16 after load; `resp_timeout`=1; `spi_rst_n` low for 2 cycles; a following req0 read completes normally.
- Assert `rst_n`=0 mid-read -> `ack`=0, `busy`=0, `spi_addr`=8'hFF, `spi_rst_n`=0 immediately; after release the pointer is 0.
